// File: rtl/pipeline_pkg.sv
// Shared pipeline types: opcodes, ALU/result selects, ID/EX bundle.
// Imported by decode_cycle, register_file and execute_cycle.
package pipeline_pkg;

    localparam int XLEN_P = 32;
    localparam int RIDX_P = 5;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_op_t;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_t;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_t;

    typedef enum logic [1:0] {
        AM_ADD   = 2'b00,
        AM_SUB   = 2'b01,
        AM_FUNCT = 2'b10
    } alu_mode_t;

    typedef struct packed {
        logic              regWrite;
        logic              memWrite;
        logic              jump;
        logic              branch;
        logic              aluSrc;
        result_src_t       resultSrc;
        alu_op_t           aluControl;
        logic              illegal;
        logic [XLEN_P-1:0] rd1;
        logic [XLEN_P-1:0] rd2;
        logic [XLEN_P-1:0] immExt;
        logic [XLEN_P-1:0] pc;
        logic [XLEN_P-1:0] pcPlus4;
        logic [RIDX_P-1:0] rs1;
        logic [RIDX_P-1:0] rs2;
        logic [RIDX_P-1:0] rd;
    } id_ex_t;

    function automatic logic [XLEN_P-1:0] immExtend(
        input logic [31:0] instr,
        input imm_src_t    immSrc
    );
        logic [XLEN_P-1:0] imm;
        imm = '0;
        unique case (immSrc)
            IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm = {{20{instr[31]}}, instr[7],
                          instr[30:25], instr[11:8], 1'b0};
            IMM_J: imm = {{12{instr[31]}}, instr[19:12],
                          instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/register_file.sv
// 2R1W register file, x0 hardwired to zero, async active-low reset.
// Optional writeback-to-read bypass under DECODE_WB_BYPASS_EN.
module register_file
    import pipeline_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    localparam int AW = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   readAddr1,
    input  logic [AW-1:0]   readAddr2,
    output logic [XLEN-1:0] readData1,
    output logic [XLEN-1:0] readData2,
    input  logic            writeEn,
    input  logic [AW-1:0]   writeAddr,
    input  logic [XLEN-1:0] writeData
);

    logic [XLEN-1:0] regs [NREG];
    logic            wrValid;

    assign wrValid = writeEn && (writeAddr != '0);

    // Storage: cleared on reset, writes to x0 dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wrValid) begin
            regs[writeAddr] <= writeData;
        end
    end

    // Read ports: x0 forced to zero, optional same-cycle bypass.
    always_comb begin
        readData1 = regs[readAddr1];
        readData2 = regs[readAddr2];
`ifdef DECODE_WB_BYPASS_EN
        if (wrValid && (writeAddr == readAddr1)) begin
            readData1 = writeData;
        end
        if (wrValid && (writeAddr == readAddr2)) begin
            readData2 = writeData;
        end
`endif
        if (readAddr1 == '0) begin
            readData1 = '0;
        end
        if (readAddr2 == '0) begin
            readData2 = '0;
        end
    end

endmodule

// File: rtl/decode_cycle.sv
// ID stage: RV32I subset decode, register read, immediate, ID/EX register.
// Same-cycle writeback bypass enabled by defining DECODE_WB_BYPASS_EN.
module decode_cycle
    import pipeline_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     InstrD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic            RegWriteW,
    input  logic [4:0]      RDW,
    input  logic [XLEN-1:0] ResultW,
    input  logic            FlushE,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic            JumpE,
    output logic            BranchE,
    output logic            ALUSrcE,
    output logic [1:0]      ResultSrcE,
    output logic [2:0]      ALUControlE,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] ImmExtE,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic [4:0]      RS1E,
    output logic [4:0]      RS2E,
    output logic [4:0]      RDE,
    output logic            IllegalE
);

    localparam int AW = $clog2(NREG);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic [4:0]      rs1D;
    logic [4:0]      rs2D;
    logic [4:0]      rdD;
    logic [XLEN-1:0] rd1D;
    logic [XLEN-1:0] rd2D;

    logic            regWriteD;
    logic            memWriteD;
    logic            jumpD;
    logic            branchD;
    logic            aluSrcD;
    logic            illegalD;
    result_src_t     resultSrcD;
    imm_src_t        immSrcD;
    alu_mode_t       aluModeD;
    alu_op_t         aluControlD;

    id_ex_t          idExD;
    id_ex_t          idExQ;

    assign opcode   = InstrD[6:0];
    assign funct3   = InstrD[14:12];
    assign funct7b5 = InstrD[30];
    assign rs1D     = InstrD[19:15];
    assign rs2D     = InstrD[24:20];
    assign rdD      = InstrD[11:7];

    register_file #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) uRegFile (
        .clk       (clk),
        .rst       (rst),
        .readAddr1 (AW'(rs1D)),
        .readAddr2 (AW'(rs2D)),
        .readData1 (rd1D),
        .readData2 (rd2D),
        .writeEn   (RegWriteW),
        .writeAddr (AW'(RDW)),
        .writeData (ResultW)
    );

    // Main decoder: opcode to control bits; unknown opcodes become bubbles.
    always_comb begin
        regWriteD  = 1'b0;
        memWriteD  = 1'b0;
        jumpD      = 1'b0;
        branchD    = 1'b0;
        aluSrcD    = 1'b0;
        illegalD   = 1'b0;
        resultSrcD = RES_ALU;
        immSrcD    = IMM_I;
        aluModeD   = AM_ADD;
        unique case (1'b1)
            (opcode == OP_LW): begin
                regWriteD  = 1'b1;
                aluSrcD    = 1'b1;
                resultSrcD = RES_MEM;
            end
            (opcode == OP_SW): begin
                memWriteD = 1'b1;
                aluSrcD   = 1'b1;
                immSrcD   = IMM_S;
            end
            (opcode == OP_R): begin
                regWriteD = 1'b1;
                aluModeD  = AM_FUNCT;
            end
            (opcode == OP_I): begin
                regWriteD = 1'b1;
                aluSrcD   = 1'b1;
                aluModeD  = AM_FUNCT;
            end
            (opcode == OP_BEQ): begin
                branchD  = 1'b1;
                immSrcD  = IMM_B;
                aluModeD = AM_SUB;
            end
            (opcode == OP_JAL): begin
                regWriteD  = 1'b1;
                jumpD      = 1'b1;
                resultSrcD = RES_PC4;
                immSrcD    = IMM_J;
            end
            default: begin
                illegalD = 1'b1;
            end
        endcase
    end

    // ALU decoder: sub only for R-type with funct7[5] set.
    always_comb begin
        aluControlD = ALU_ADD;
        unique case (aluModeD)
            AM_ADD: aluControlD = ALU_ADD;
            AM_SUB: aluControlD = ALU_SUB;
            AM_FUNCT: begin
                unique case (funct3)
                    3'b000: aluControlD =
                        (opcode == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010: aluControlD = ALU_SLT;
                    3'b110: aluControlD = ALU_OR;
                    3'b111: aluControlD = ALU_AND;
                    default: aluControlD = ALU_ADD;
                endcase
            end
            default: aluControlD = ALU_ADD;
        endcase
    end

    // Assemble the ID/EX bundle for the next edge.
    always_comb begin
        idExD            = '0;
        idExD.regWrite   = regWriteD;
        idExD.memWrite   = memWriteD;
        idExD.jump       = jumpD;
        idExD.branch     = branchD;
        idExD.aluSrc     = aluSrcD;
        idExD.resultSrc  = resultSrcD;
        idExD.aluControl = aluControlD;
        idExD.illegal    = illegalD;
        idExD.rd1        = rd1D;
        idExD.rd2        = rd2D;
        idExD.immExt     = immExtend(InstrD, immSrcD);
        idExD.pc         = PCD;
        idExD.pcPlus4    = PCPlus4D;
        idExD.rs1        = rs1D;
        idExD.rs2        = rs2D;
        idExD.rd         = rdD;
    end

    // ID/EX register: flush inserts an all-zero bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idExQ <= '0;
        end else if (FlushE) begin
            idExQ <= '0;
        end else begin
            idExQ <= idExD;
        end
    end

    assign RegWriteE   = idExQ.regWrite;
    assign MemWriteE   = idExQ.memWrite;
    assign JumpE       = idExQ.jump;
    assign BranchE     = idExQ.branch;
    assign ALUSrcE     = idExQ.aluSrc;
    assign ResultSrcE  = idExQ.resultSrc;
    assign ALUControlE = idExQ.aluControl;
    assign IllegalE    = idExQ.illegal;
    assign RD1E        = idExQ.rd1;
    assign RD2E        = idExQ.rd2;
    assign ImmExtE     = idExQ.immExt;
    assign PCE         = idExQ.pc;
    assign PCPlus4E    = idExQ.pcPlus4;
    assign RS1E        = idExQ.rs1;
    assign RS2E        = idExQ.rs2;
    assign RDE         = idExQ.rd;

endmodule

// File: tb/tb_decode_cycle.sv
// Directed scoreboard bench for decode_cycle.
// Expected ID/EX contents are queued at drive time, checked after the edge.
module tb_decode_cycle;

    logic        clk;
    logic        rst;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        RegWriteW;
    logic [4:0]  RDW;
    logic [31:0] ResultW;
    logic        FlushE;
    logic        RegWriteE;
    logic        MemWriteE;
    logic        JumpE;
    logic        BranchE;
    logic        ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E;
    logic [31:0] RD2E;
    logic [31:0] ImmExtE;
    logic [31:0] PCE;
    logic [31:0] PCPlus4E;
    logic [4:0]  RS1E;
    logic [4:0]  RS2E;
    logic [4:0]  RDE;
    logic        IllegalE;

    typedef struct {
        logic        rw;
        logic        mw;
        logic        jmp;
        logic        br;
        logic        asrc;
        logic [1:0]  rsrc;
        logic [2:0]  alu;
        logic        ill;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [4:0]  rd;
        bit          chkData;
        bit          chkImm;
        bit          chkAsrc;
    } exp_t;

    exp_t        sbq[$];
    int          checks;
    int          failures;
    logic [31:0] pcCnt;

    decode_cycle dut (
        .clk         (clk),
        .rst         (rst),
        .InstrD      (InstrD),
        .PCD         (PCD),
        .PCPlus4D    (PCPlus4D),
        .RegWriteW   (RegWriteW),
        .RDW         (RDW),
        .ResultW     (ResultW),
        .FlushE      (FlushE),
        .RegWriteE   (RegWriteE),
        .MemWriteE   (MemWriteE),
        .JumpE       (JumpE),
        .BranchE     (BranchE),
        .ALUSrcE     (ALUSrcE),
        .ResultSrcE  (ResultSrcE),
        .ALUControlE (ALUControlE),
        .RD1E        (RD1E),
        .RD2E        (RD2E),
        .ImmExtE     (ImmExtE),
        .PCE         (PCE),
        .PCPlus4E    (PCPlus4E),
        .RS1E        (RS1E),
        .RS2E        (RS2E),
        .RDE         (RDE),
        .IllegalE    (IllegalE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(
        input logic rw, input logic mw, input logic jmp,
        input logic br, input logic asrc, input logic [1:0] rsrc,
        input logic [2:0] alu, input logic ill,
        input logic [31:0] rd1, input logic [31:0] rd2,
        input logic [31:0] imm,
        input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd
    );
        exp_t e;
        e.rw = rw; e.mw = mw; e.jmp = jmp; e.br = br;
        e.asrc = asrc; e.rsrc = rsrc; e.alu = alu; e.ill = ill;
        e.rd1 = rd1; e.rd2 = rd2; e.imm = imm;
        e.pc = '0; e.pc4 = '0;
        e.r1 = r1; e.r2 = r2; e.rd = rd;
        e.chkData = 1'b1; e.chkImm = 1'b1; e.chkAsrc = 1'b1;
        return e;
    endfunction

    function automatic logic [31:0] rtype(input logic [6:0] f7,
        input logic [4:0] r2, input logic [4:0] r1,
        input logic [2:0] f3, input logic [4:0] rd);
        return {f7, r2, r1, f3, rd, 7'b0110011};
    endfunction

    task automatic cmp(input string t, input exp_t e);
        chk({t, ".RegWriteE"}, 32'(RegWriteE), 32'(e.rw));
        chk({t, ".MemWriteE"}, 32'(MemWriteE), 32'(e.mw));
        chk({t, ".JumpE"}, 32'(JumpE), 32'(e.jmp));
        chk({t, ".BranchE"}, 32'(BranchE), 32'(e.br));
        chk({t, ".ResultSrcE"}, 32'(ResultSrcE), 32'(e.rsrc));
        chk({t, ".ALUControlE"}, 32'(ALUControlE), 32'(e.alu));
        chk({t, ".IllegalE"}, 32'(IllegalE), 32'(e.ill));
        chk({t, ".RS1E"}, 32'(RS1E), 32'(e.r1));
        chk({t, ".RS2E"}, 32'(RS2E), 32'(e.r2));
        chk({t, ".RDE"}, 32'(RDE), 32'(e.rd));
        if (e.chkAsrc) chk({t, ".ALUSrcE"}, 32'(ALUSrcE), 32'(e.asrc));
        if (e.chkData) begin
            chk({t, ".RD1E"}, RD1E, e.rd1);
            chk({t, ".RD2E"}, RD2E, e.rd2);
            chk({t, ".PCE"}, PCE, e.pc);
            chk({t, ".PCPlus4E"}, PCPlus4E, e.pc4);
            if (e.chkImm) chk({t, ".ImmExtE"}, ImmExtE, e.imm);
        end
    endtask

    task automatic allZero(input string t);
        exp_t z;
        z = mk(0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 0, 0, 0, 0);
        z.pc = '0; z.pc4 = '0;
        cmp(t, z);
    endtask

    task automatic step(input string t, input logic [31:0] instr,
                        input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic fl,
                        input exp_t e);
        exp_t got;
        @(negedge clk);
        InstrD = instr; PCD = pcCnt; PCPlus4D = pcCnt + 32'd4;
        RegWriteW = we; RDW = wa; ResultW = wd; FlushE = fl;
        e.pc = pcCnt; e.pc4 = pcCnt + 32'd4;
        sbq.push_back(e);
        pcCnt = pcCnt + 32'd4;
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s scoreboard empty observed=0 expected=1", t);
        end else begin
            got = sbq.pop_front();
            cmp(t, got);
        end
    endtask

    localparam logic [31:0] NOP = 32'h00000013;

    initial begin
        exp_t e;
        exp_t nopE;
        logic [31:0] x3Old;
        checks = 0; failures = 0; pcCnt = 32'h100;
        rst = 1'b0; InstrD = '0; PCD = '0; PCPlus4D = '0;
        RegWriteW = 1'b0; RDW = '0; ResultW = '0; FlushE = 1'b0;
        nopE = mk(1, 0, 0, 0, 1, 2'b00, 3'b000, 0, 0, 0, 0, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        allZero("reset");
        @(negedge clk);
        rst = 1'b1;

        for (int i = 1; i < 32; i += 2) begin
            e = mk(1, 0, 0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 0,
                   5'(i), 5'(32 - i), 5'd5);
            e.chkImm = 1'b0;
            step("rstread", rtype(7'd0, 5'(32 - i), 5'(i), 3'd0, 5'd5),
                 0, 0, 0, 0, e);
        end

        step("wr_x1", NOP, 1, 5'd1, 32'd5, 0, nopE);
        e = mk(1, 0, 0, 0, 1, 2'b00, 3'b000, 0, 32'd5, 0,
               32'hFFFFFFFD, 5'd1, 5'd29, 5'd2);
        step("addi", 32'hFFD08113, 0, 0, 0, 0, e);

        e = mk(0, 0, 0, 1, 0, 2'b00, 3'b001, 0, 0, 0,
               32'hFFFFFFF8, 5'd0, 5'd0, 5'd25);
        step("beq", 32'hFE000CE3, 0, 0, 0, 0, e);

        step("wr_x3", NOP, 1, 5'd3, 32'h1111, 0, nopE);
`ifdef DECODE_WB_BYPASS_EN
        x3Old = 32'h0000ABCD;
`else
        x3Old = 32'h00001111;
`endif
        e = mk(1, 0, 0, 0, 0, 2'b00, 3'b000, 0, x3Old, 0, 0,
               5'd3, 5'd0, 5'd6);
        e.chkImm = 1'b0;
        step("samecyc", rtype(7'd0, 5'd0, 5'd3, 3'd0, 5'd6),
             1, 5'd3, 32'hABCD, 0, e);

        e = mk(1, 0, 0, 0, 0, 2'b00, 3'b000, 0, 32'hABCD, 0, 0,
               5'd3, 5'd0, 5'd6);
        e.chkImm = 1'b0;
        step("x0wr", rtype(7'd0, 5'd0, 5'd3, 3'd0, 5'd6),
             1, 5'd0, 32'h5555, 0, e);

        e = mk(0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 0, 0, 0, 0);
        e.chkData = 1'b0;
        step("flush", 32'h0040A423, 1, 5'd4, 32'h44, 1, e);

        e = mk(0, 1, 0, 0, 1, 2'b00, 3'b000, 0, 32'd5, 32'h44,
               32'd8, 5'd1, 5'd4, 5'd8);
        step("sw", 32'h0040A423, 0, 0, 0, 0, e);

        e = mk(1, 0, 0, 0, 1, 2'b01, 3'b000, 0, 32'd5, 0,
               32'hFFFFFFFC, 5'd1, 5'd28, 5'd7);
        step("lw", 32'hFFC0A383, 0, 0, 0, 0, e);

        e = mk(1, 0, 0, 0, 0, 2'b00, 3'b001, 0, 0, 32'd5, 0,
               5'd2, 5'd1, 5'd8);
        e.chkImm = 1'b0;
        step("sub", 32'h40110433, 0, 0, 0, 0, e);

        e = mk(1, 0, 0, 0, 0, 2'b00, 3'b010, 0, 32'd5, 32'h44, 0,
               5'd1, 5'd4, 5'd9);
        e.chkImm = 1'b0;
        step("and", 32'h0040F4B3, 0, 0, 0, 0, e);

        e = mk(1, 0, 0, 0, 1, 2'b00, 3'b011, 0, 32'd5, 0,
               32'd16, 5'd1, 5'd16, 5'd10);
        step("ori", 32'h0100E513, 0, 0, 0, 0, e);

        e = mk(1, 0, 0, 0, 1, 2'b00, 3'b101, 0, 32'd5, 0,
               32'hFFFFFFFF, 5'd1, 5'd31, 5'd11);
        step("slti", 32'hFFF0A593, 0, 0, 0, 0, e);

        e = mk(1, 0, 0, 0, 0, 2'b00, 3'b101, 0, 32'd5, 32'h44, 0,
               5'd1, 5'd4, 5'd12);
        e.chkImm = 1'b0;
        step("slt", 32'h0040A633, 0, 0, 0, 0, e);

        e = mk(1, 0, 1, 0, 0, 2'b10, 3'b000, 0, 0, 0,
               32'hFFFFFFFC, 5'd31, 5'd29, 5'd1);
        e.chkAsrc = 1'b0;
        step("jal", 32'hFFDFF0EF, 0, 0, 0, 0, e);

        e = mk(0, 0, 0, 0, 0, 2'b00, 3'b000, 1, 32'd5, 0, 0,
               5'd1, 5'd2, 5'd0);
        e.chkImm = 1'b0;
        step("illegal", 32'h0020807F, 0, 0, 0, 0, e);

        @(negedge clk);
        InstrD = 32'h0040A423; RegWriteW = 1'b0; FlushE = 1'b0;
        @(posedge clk);
        #2;
        chk("pre_async.MemWriteE", 32'(MemWriteE), 32'd1);
        rst = 1'b0;
        #1;
        allZero("async_rst");
        @(negedge clk);
        rst = 1'b1;

        e = mk(1, 0, 0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 0,
               5'd1, 5'd4, 5'd5);
        e.chkImm = 1'b0;
        step("post_rst", rtype(7'd0, 5'd4, 5'd1, 3'd0, 5'd5),
             0, 0, 0, 0, e);

        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_cycle.md
# decode_cycle

Decode stage of the five-stage pipeline, consuming the IF/ID outputs of `fetch_cycle` (`InstrD`, `PCD`, `PCPlus4D`). It decodes an RV32I subset, reads and writes the 32-entry register file, and generates the immediate and control signals. It registers everything into the ID/EX pipeline register for the execute stage, which returns `PCSrcE`/`PCTargetE` to fetch.

## Interface
- `XLEN`, 32: data and PC width.
- `NREG`, 32: register count. Index width is `$clog2(NREG)`.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `InstrD` input 32: instruction from IF/ID.
- `PCD`, `PCPlus4D` input XLEN: PC and PC+4 from IF/ID.
- `RegWriteW` input 1: writeback enable.
- `RDW` input 5: writeback destination.
- `ResultW` input XLEN: writeback data.
- `FlushE` input 1: synchronous bubble insert into ID/EX (from hazard unit).
- `RegWriteE`, `MemWriteE`, `JumpE`, `BranchE`, `ALUSrcE` output 1: registered control signals.
- `ResultSrcE` output 2: result select. 00 = ALU, 01 = memory, 10 = PC+4.
- `ALUControlE` output 3: ALU operation. 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.
- `RD1E`, `RD2E`, `ImmExtE`, `PCE`, `PCPlus4E` output XLEN: registered operands, immediate and PCs.
- `RS1E`, `RS2E`, `RDE` output 5: registered register indices, used for forwarding.
- `IllegalE` output 1: registered flag for an unsupported opcode.

## Operation
- **Supported opcodes:**
  - 0000011 `lw`
  - 0100011 `sw`
  - 0110011 R-type: add, sub, and, or, slt
  - 0010011 I-type ALU: addi, andi, ori, slti
  - 1100011 `beq`
  - 1101111 `jal`
- **Control decode:** combinational main decoder plus ALU decoder.
  - `sub` is selected only by R-type with funct7[5] = 1.
  - `beq` forces `ALUControl` = sub.
  - `lw`, `sw` and `jal` force `ALUControl` = add.
- **Immediates, all sign-extended from `InstrD[31]`:**
  - I-type: `{InstrD[31:20]}`
  - S-type: `{InstrD[31:25], InstrD[11:7]}`
  - B-type: `{InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0}`
  - J-type: `{InstrD[31], InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0}`
- **Illegal opcode:**
  - All control signals are forced to 0, so the instruction becomes a bubble.
  - `IllegalE` is set to 1 in the next cycle.
  - Data fields are still captured.
- **Register file:**
  - Two asynchronous read ports, addressed by `InstrD[19:15]` and `InstrD[24:20]`.
  - One synchronous write port on the rising edge of `clk` when `RegWriteW` = 1 and `RDW` ≠ 0.
  - x0 always reads 0; writes to x0 are discarded.
- **ID/EX register:**
  - Captures all `*E` outputs on every rising edge.
  - There is no stall input. Decode stalls are handled upstream by the IF/ID enable.
- **`FlushE` = 1 at an edge:**
  - Clears `RegWriteE`, `MemWriteE`, `JumpE`, `BranchE`, `ALUSrcE`, `ResultSrcE`, `ALUControlE` and `IllegalE` to 0.
  - Clears `RS1E`, `RS2E` and `RDE` to 0, so no false forwarding occurs.
  - Data fields are don't-care; the implementation clears them to 0.

## Timing
- **Reset:** `rst` = 0 asynchronously clears every `*E` output to 0 and all registers x1..x31 to 0. Release takes effect at the first rising edge with `rst` = 1.
- **Latency:** decode is 1 cycle. `InstrD` presented before edge N appears on the `*E` outputs after edge N.
- **Writeback vs read:** a write at edge N is visible to combinational reads after edge N.
- **Same-cycle write and read of the same register:** governed by the macro in Configuration.
- **Flush priority:**
  - `FlushE` takes priority over decoded values.
  - A register-file write in the same cycle as `FlushE` still commits.
- **Reset mid-operation:** the pipeline contents and the register file are lost. No partial write completes.

## Configuration
- `DECODE_WB_BYPASS_EN`, when defined:
  - A read port whose address equals `RDW` while `RegWriteW` = 1 and `RDW` ≠ 0 returns `ResultW` combinationally.
  - The instruction in decode therefore captures the newly written value at the same edge.
- When `DECODE_WB_BYPASS_EN` is undefined:
  - The read returns the old register value.
  - The hazard unit must stall one extra cycle for this case.

## Structure
- **Shared package `pipeline_pkg`:**
  - Opcode constants.
  - `alu_op_t` (3-bit enum).
  - `result_src_t` (2-bit enum).
  - `id_ex_t` packed struct holding all ID/EX fields, shared with `execute_cycle`.
- **Sub-module `register_file`:**
  - Ports: `clk`, `rst`, two read ports, one write port.
  - The bypass logic is placed inside `register_file`, under the macro.
- The control decoder and immediate extender stay inline in `decode_cycle`.

## Test plan
- **Reset:** hold `rst` = 0 for 2 cycles → all `*E` outputs are 0 and reads of x1..x31 return 0.
- **addi:** write x1 = 5 through W, then decode `addi x2,x1,-3` (0xFFD08113) → `RD1E` = 5, `ImmExtE` = 0xFFFFFFFD, `ALUSrcE` = 1, `RegWriteE` = 1, `ALUControlE` = 000, `RDE` = 2.
- **beq:** decode `beq x0,x0,-8` (0xFE000CE3) → `BranchE` = 1, `ALUControlE` = 001, `ImmExtE` = 0xFFFFFFF8, `RegWriteE` = 0.
- **Same-cycle write/read:** `RegWriteW` = 1, `RDW` = 3, `ResultW` = 0xABCD, with `InstrD` reading x3.
  - With the macro defined → `RD1E` = 0xABCD.
  - Without it → old value.
  - Also drive `RDW` = 0 → x0 still reads 0.
- **Flush:** `FlushE` = 1 while decoding a `sw` → all controls and `RDE` are 0. The concurrent W write to x4 still commits.
- **Illegal opcode and async reset:**
  - Opcode 0x7F → `IllegalE` = 1 and all controls 0.
  - Assert `rst` between clock edges → outputs clear immediately.
